// File: rtl/fma_pkg.sv
// Shared definitions for the fixed-point FMA datapath and its output stages.
package fma_pkg;

  localparam logic [1:0] RM_RNE   = 2'd0;
  localparam logic [1:0] RM_RTZ   = 2'd1;
  localparam logic [1:0] RM_FLOOR = 2'd2;
  localparam logic [1:0] RM_CEIL  = 2'd3;

  localparam int FMA_INTW  = 16;
  localparam int FMA_FRACW = 16;
  localparam int FMA_OINTW = 16;
  localparam int FMA_CNTW  = 16;

endpackage

// File: rtl/fxp_round_dec.sv
// Rounding decision: derives the +1 increment and the inexact flag from
// the bits being discarded by a right shift of FRACW.
module fxp_round_dec
  import fma_pkg::*;
#(
  parameter int FRACW = FMA_FRACW
) (
  input  logic             q_lsb,
  input  logic             sign,
  input  logic [FRACW-1:0] frac,
  input  logic [1:0]       rmode,
  output logic             inc,
  output logic             inexact
);

  logic half;
  logic rest;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    inc     = 1'b0;
    half    = frac[FRACW-1];
    rest    = |frac[FRACW-2:0];
    inexact = |frac;
    case (rmode)
      RM_RNE:   inc = half & (rest | q_lsb);
      RM_RTZ:   inc = sign & inexact;
      RM_FLOOR: inc = 1'b0;
      default:  inc = inexact;
    endcase
  end

endmodule

// File: rtl/fma_round_sat.sv
// Output conditioning for the FMA core: round the wide result to FRACW
// fraction bits, saturate to OINTW.FRACW, and count clamp events.
module fma_round_sat
  import fma_pkg::*;
#(
  parameter int INTW  = FMA_INTW,
  parameter int FRACW = FMA_FRACW,
  parameter int OINTW = FMA_OINTW,
  parameter int CNTW  = FMA_CNTW
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INTW+2*FRACW-1:0]   in_data,
  input  logic [1:0]                in_rmode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OINTW+FRACW-1:0]    out_data,
  output logic                      out_sat,
  output logic                      out_inexact,
  output logic [CNTW-1:0]           sat_count,
  input  logic                      sat_clr
);

  localparam int QW = INTW + FRACW;
  localparam int OW = OINTW + FRACW;
  localparam logic signed [QW:0] MAX_POS = {{(QW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [QW:0] MIN_NEG = ~MAX_POS;

  logic [QW-1:0]    q_in;
  logic [FRACW-1:0] d_in;
  logic             sign_in;
  logic             inc_in;
  logic             inexact_in;

  // The low QW bits of in_data >>> FRACW are exactly the upper slice.
  assign q_in    = in_data[INTW+2*FRACW-1:FRACW];
  assign d_in    = in_data[FRACW-1:0];
  assign sign_in = in_data[INTW+2*FRACW-1];

  fxp_round_dec #(.FRACW(FRACW)) u_round_dec (
    .q_lsb   (q_in[0]),
    .sign    (sign_in),
    .frac    (d_in),
    .rmode   (in_rmode),
    .inc     (inc_in),
    .inexact (inexact_in)
  );

  logic          v1;
  logic [QW-1:0] q1;
  logic          inc1;
  logic          inexact1;
  logic          sign1;
  logic          load1;
  logic          load2;

  assign load2    = !out_valid | out_ready;
  assign load1    = !v1 | load2;
  assign in_ready = load1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1       <= 1'b0;
      q1       <= '0;
      inc1     <= 1'b0;
      inexact1 <= 1'b0;
      sign1    <= 1'b0;
    end else if (load1) begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      v1 <= in_valid;
      if (in_valid) begin
        q1       <= q_in;
        inc1     <= inc_in;
        inexact1 <= inexact_in;
        sign1    <= sign_in;
      end
    end
  end

  // One extra bit of headroom so q + inc can never wrap.
  logic signed [QW:0] r;
  logic               sat_hi;
  logic               sat_lo;
  logic [OW-1:0]      data_next;

  assign r         = $signed({sign1, q1}) + $signed({{QW{1'b0}}, inc1});
  assign sat_hi    = r > MAX_POS;
  assign sat_lo    = r < MIN_NEG;
  assign data_next = sat_hi ? MAX_POS[OW-1:0] : (sat_lo ? MIN_NEG[OW-1:0] : r[OW-1:0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: data registers are reset too, so the output reads zero out of reset.
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sat     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (load2) begin
      out_valid <= v1;
      if (v1) begin
        out_data    <= data_next;
        out_sat     <= sat_hi | sat_lo;
        out_inexact <= inexact1;
      end
    end
  end

  logic sat_xfer;
  assign sat_xfer = out_valid & out_ready & out_sat;

  // A clear coinciding with an event leaves 1 so the event is not lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= sat_xfer ? CNTW'(1) : '0;
    end else if (sat_xfer && !(&sat_count)) begin
      sat_count <= sat_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fma_round_sat.sv
// Bench for fma_round_sat: default-width instance plus an OINTW=8/CNTW=2
// instance, checked against an arithmetic reference model and literals.
module tb_fma_round_sat;
  import fma_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    longint data;
    bit     sat;
    bit     inex;
  } beat_t;

  // Instance A: default widths
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat, a_out_inexact, a_sat_clr;
  logic [47:0] a_in_data;
  logic [1:0]  a_in_rmode;
  logic [31:0] a_out_data;
  logic [15:0] a_sat_count;

  // Instance B: OINTW=8, CNTW=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat, b_out_inexact, b_sat_clr;
  logic [47:0] b_in_data;
  logic [1:0]  b_in_rmode;
  logic [23:0] b_out_data;
  logic [1:0]  b_sat_count;

  fma_round_sat dut_a (
    .clk(clk), .rstn(rstn),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_rmode(a_in_rmode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .out_inexact(a_out_inexact),
    .sat_count(a_sat_count), .sat_clr(a_sat_clr)
  );

  fma_round_sat #(.OINTW(8), .CNTW(2)) dut_b (
    .clk(clk), .rstn(rstn),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_rmode(b_in_rmode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .out_inexact(b_out_inexact),
    .sat_count(b_sat_count), .sat_clr(b_sat_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: round x / 2^16 by mode using plain integer arithmetic, then clamp.
  function automatic void model(input logic [47:0] d, input logic [1:0] rm, input int oint,
                                output longint od, output bit sat, output bit inex);
    logic signed [47:0] ds;
    longint x, q, fr, r, maxv, minv;
    ds = d;
    x  = ds;
    q  = x / 65536;
    if (q * 65536 > x) q = q - 1;
    fr   = x - q * 65536;
    inex = (fr != 0);
    case (rm)
      RM_RNE:   r = q + (((fr > 32768) || (fr == 32768 && (q & 64'sd1) != 0)) ? 1 : 0);
      RM_RTZ:   r = (x < 0 && inex) ? q + 1 : q;
      RM_FLOOR: r = q;
      default:  r = inex ? q + 1 : q;
    endcase
    maxv = (longint'(1) <<< (oint + 15)) - 1;
    minv = -maxv - 1;
    sat  = 1'b0;
    if (r > maxv) begin r = maxv; sat = 1'b1; end
    if (r < minv) begin r = minv; sat = 1'b1; end
    od = r & ((longint'(1) <<< (oint + 16)) - 1);
  endfunction

  // Monitors run mid-cycle: they see exactly the handshakes the next edge performs.
  beat_t       qa[$];
  beat_t       qb[$];
  int          a_out_cnt = 0;
  int          b_out_cnt = 0;
  logic [31:0] a_last_data;
  logic [23:0] b_last_data;
  logic        a_last_sat, a_last_inex, b_last_sat, b_last_inex;
  bit          a_held = 0;
  bit          b_held = 0;
  logic [31:0] a_hd;
  logic [23:0] b_hd;
  logic        a_hs, a_hi, b_hs, b_hi;

  always @(negedge clk) begin : mon_a
    beat_t e;
    if (!rstn) begin
      qa.delete();
      a_held = 0;
    end else begin
      if (a_held) begin
        check("a_stall_valid", a_out_valid, 1);
        check("a_stall_data", a_out_data, a_hd);
        check("a_stall_sat", a_out_sat, a_hs);
        check("a_stall_inexact", a_out_inexact, a_hi);
      end
      a_held = a_out_valid && !a_out_ready;
      a_hd = a_out_data; a_hs = a_out_sat; a_hi = a_out_inexact;
      if (a_in_valid && a_in_ready) begin
        model(a_in_data, a_in_rmode, 16, e.data, e.sat, e.inex);
        qa.push_back(e);
      end
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) check("a_unexpected_beat", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_data", a_out_data, e.data);
          check("a_sat", a_out_sat, e.sat);
          check("a_inexact", a_out_inexact, e.inex);
        end
        a_last_data = a_out_data; a_last_sat = a_out_sat; a_last_inex = a_out_inexact;
        a_out_cnt++;
      end
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t e;
    if (!rstn) begin
      qb.delete();
      b_held = 0;
    end else begin
      if (b_held) begin
        check("b_stall_data", b_out_data, b_hd);
        check("b_stall_flags", {b_out_valid, b_out_sat, b_out_inexact}, {1'b1, b_hs, b_hi});
      end
      b_held = b_out_valid && !b_out_ready;
      b_hd = b_out_data; b_hs = b_out_sat; b_hi = b_out_inexact;
      if (b_in_valid && b_in_ready) begin
        model(b_in_data, b_in_rmode, 8, e.data, e.sat, e.inex);
        qb.push_back(e);
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) check("b_unexpected_beat", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_data", b_out_data, e.data);
          check("b_sat", b_out_sat, e.sat);
          check("b_inexact", b_out_inexact, e.inex);
        end
        b_last_data = b_out_data; b_last_sat = b_out_sat; b_last_inex = b_out_inexact;
        b_out_cnt++;
      end
    end
  end

  // Drivers are called at posedge+1 and return at posedge+1 after acceptance.
  task automatic send_a(input logic [47:0] d, input logic [1:0] rm);
    int n = 0;
    bit acc = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_rmode = rm;
    do begin
      @(negedge clk); acc = a_in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) check("a_send_timeout", 0, 1);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [47:0] d, input logic [1:0] rm);
    int n = 0;
    bit acc = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_rmode = rm;
    do begin
      @(negedge clk); acc = b_in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) check("b_send_timeout", 0, 1);
    b_in_valid = 1'b0;
  endtask

  task automatic wait_out_a(input int target);
    int n = 0;
    while (a_out_cnt < target && n < 100) begin @(posedge clk); #1; n++; end
    if (a_out_cnt < target) check("a_out_timeout", a_out_cnt, target);
  endtask

  task automatic wait_out_b(input int target);
    int n = 0;
    while (b_out_cnt < target && n < 100) begin @(posedge clk); #1; n++; end
    if (b_out_cnt < target) check("b_out_timeout", b_out_cnt, target);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] rnd;
    int          n;
    int          base;

    rstn = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_in_rmode = RM_RNE; a_out_ready = 1; a_sat_clr = 0;
    b_in_valid = 0; b_in_data = '0; b_in_rmode = RM_RNE; b_out_ready = 1; b_sat_clr = 0;
    #12;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_word", {a_out_data, a_out_sat, a_out_inexact}, 0);
    check("rst_sat_count", a_sat_count, 0);
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;

    // Round to nearest even, and the two-cycle latency
    send_a(48'h0000_0001_8000, RM_RNE);
    check("latency_edge1", a_out_valid, 0);
    @(posedge clk); #1;
    check("latency_edge2", a_out_valid, 1);
    wait_out_a(1);
    check("rne_up_data", a_last_data, 32'h0000_0002);
    check("rne_up_inexact", a_last_inex, 1);
    send_a(48'h0000_0002_8000, RM_RNE);
    wait_out_a(2);
    check("rne_tie_even", a_last_data, 32'h0000_0002);

    // Negative -1.5 under the directed modes
    send_a(48'hFFFF_FFFE_8000, RM_RTZ);
    wait_out_a(3);
    check("neg_rtz", {a_last_data, a_last_inex}, {32'hFFFF_FFFF, 1'b1});
    send_a(48'hFFFF_FFFE_8000, RM_FLOOR);
    wait_out_a(4);
    check("neg_floor", {a_last_data, a_last_inex}, {32'hFFFF_FFFE, 1'b1});
    send_a(48'hFFFF_FFFE_8000, RM_CEIL);
    wait_out_a(5);
    check("neg_ceil", {a_last_data, a_last_inex}, {32'hFFFF_FFFF, 1'b1});

    // Positive overflow caused only by the rounding increment
    check("cnt_before_sat", a_sat_count, 0);
    send_a(48'h7FFF_FFFF_8000, RM_CEIL);
    wait_out_a(6);
    check("sat_max_data", a_last_data, 32'h7FFF_FFFF);
    check("sat_max_flag", a_last_sat, 1);
    check("cnt_after_sat", a_sat_count, 1);

    // Full pipeline under backpressure
    a_out_ready = 1'b0;
    send_a(48'h0000_0005_0000, RM_FLOOR);
    send_a(48'h0000_0006_4000, RM_CEIL);
    check("full_in_ready", a_in_ready, 0);
    check("full_out_valid", a_out_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    check("full_in_ready_hold", a_in_ready, 0);
    a_out_ready = 1'b1;
    wait_out_a(8);
    check("full_second_beat", a_last_data, 32'h0000_0007);

    // Random stream with random out_ready
    base = a_out_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rnd = {$urandom(), $urandom()};
          if (i % 3 == 0) rnd[47:34] = {14{rnd[33]}};
          send_a(rnd[47:0], 2'($urandom_range(0, 3)));
        end
      end
      begin
        repeat (60) begin
          @(posedge clk); #1;
          a_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    a_out_ready = 1'b1;
    wait_out_a(base + 10);
    check("stream_count", a_out_cnt - base, 10);
    check("stream_sb_empty", qa.size(), 0);

    // Narrow output: clamp at both ends, counter sticks at all-ones
    send_b(48'h0100_0000_0000, RM_RNE);
    wait_out_b(1);
    check("b_sat_pos", {b_last_data, b_last_sat}, {24'h7F_FFFF, 1'b1});
    send_b(48'hFF00_0000_0000, RM_RNE);
    wait_out_b(2);
    check("b_sat_neg", {b_last_data, b_last_sat, b_last_inex}, {24'h80_0000, 1'b1, 1'b0});
    check("b_cnt_2", b_sat_count, 2);
    send_b(48'h0100_0000_0000, RM_FLOOR);
    wait_out_b(3);
    check("b_cnt_3", b_sat_count, 3);
    send_b(48'hFF00_0000_0001, RM_CEIL);
    wait_out_b(4);
    check("b_cnt_stick", b_sat_count, 3);

    b_sat_clr = 1'b1;
    @(posedge clk); #1;
    b_sat_clr = 1'b0;
    check("b_clr_alone", b_sat_count, 0);

    send_b(48'h7000_0000_0000, RM_RTZ);
    n = 0;
    while (!b_out_valid && n < 10) begin @(negedge clk); n++; end
    if (!b_out_valid) check("b_clr_wait_timeout", 0, 1);
    #1 b_sat_clr = 1'b1;
    @(posedge clk); #1;
    b_sat_clr = 1'b0;
    check("b_clr_with_event", b_sat_count, 1);

    // Reset while two beats are held in the pipeline
    a_out_ready = 1'b0;
    send_a(48'h0000_0009_0000, RM_RNE);
    send_a(48'h7FFF_FFFF_FFFF, RM_CEIL);
    #2 rstn = 1'b0;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_sat_count", a_sat_count, 0);
    check("midrst_b_sat_count", b_sat_count, 0);
    check("midrst_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    base = a_out_cnt;
    send_a(48'h0000_0003_4000, RM_RTZ);
    wait_out_a(base + 1);
    check("post_rst_beat", a_last_data, 32'h0000_0003);
    check("post_rst_count", a_out_cnt - base, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
